stream_pattern_gen: RTL and testbench

Programmable AXI-Stream master that transmits a configured number of packets with deterministic test data. It is the transmit-side companion to the stream observer counters: it drives a stream into a reconfigurable partition or DMA sink, and the observer at the far end checks beat and TLAST totals. Software loads the configuration, pulses start, and polls busy and done.

---
 rtl/stream_gen_pkg.sv | 16 +
 rtl/stream_beat_ctr.sv | 59 +++++
 rtl/stream_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_stream_pattern_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_gen_pkg.sv
// Shared types and constants for the stream pattern generator.
package stream_gen_pkg;

    // Run sequencing states of the generator FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } gen_state_t;

    // Data pattern selection.
    localparam logic MODE_INC   = 1'b0;
    localparam logic MODE_CONST = 1'b1;

endpackage

// File: rtl/stream_beat_ctr.sv
// Beat, packet and gap counters for the stream pattern generator.
// last_beat/last_pkt describe the beat currently presented; next_last
// tells the FSM whether the beat that follows a handshake is a TLAST beat,
// so TLAST can be registered together with the next data word.
module stream_beat_ctr #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 beat_hs,
    input  logic                 gap_en,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    input  logic [LEN_WIDTH-1:0] pkt_cnt,
    input  logic [LEN_WIDTH-1:0] gap,
    output logic                 last_beat,
    output logic                 last_pkt,
    output logic                 next_last,
    output logic                 gap_last
);

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [LEN_WIDTH-1:0] pkt_idx;
    logic [LEN_WIDTH-1:0] gap_cnt;
    logic [LEN_WIDTH-1:0] beat_inc;

    // Beat index within the packet and packet index within the run.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            beat_cnt <= '0;
            pkt_idx  <= '0;
        end else if (beat_hs) begin
            if (last_beat) begin
                beat_cnt <= '0;
                pkt_idx  <= pkt_idx + ONE;
            end else begin
                beat_cnt <= beat_inc;
            end
        end
    end

    // Idle cycles spent in the inter-packet gap; parked at zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst || !gap_en) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + ONE;
        end
    end

    assign beat_inc  = beat_cnt + ONE;
    assign last_beat = (beat_cnt == pkt_len - ONE);
    assign last_pkt  = (pkt_idx == pkt_cnt - ONE);
    assign next_last = last_beat ? (pkt_len == ONE) : (beat_inc == pkt_len - ONE);
    assign gap_last  = (gap_cnt == gap - ONE);

endmodule

// File: rtl/stream_pattern_gen.sv
// Programmable AXI-Stream master: sends cfg_pkt_cnt packets of cfg_pkt_len
// beats with incrementing or constant data, optional idle gaps between
// packets, and abort support. All outputs are registered; the next beat's
// TDATA/TKEEP/TLAST are loaded on the handshake that retires the current one.
module stream_pattern_gen
    import stream_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
    input  logic [LEN_WIDTH-1:0]    cfg_pkt_cnt,
    input  logic [LEN_WIDTH-1:0]    cfg_gap,
    input  logic                    cfg_mode,
    input  logic [DATA_WIDTH-1:0]   cfg_seed,
    input  logic [DATA_WIDTH/8-1:0] cfg_last_keep,
    output logic [DATA_WIDTH-1:0]   M_AXI_TDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_TKEEP,
    output logic                    M_AXI_TVALID,
    input  logic                    M_AXI_TREADY,
    output logic                    M_AXI_TLAST,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [31:0]             beats_sent
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    gen_state_t              state;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    cnt_q;
    logic [LEN_WIDTH-1:0]    gap_q;
    logic                    mode_q;
    logic [DATA_WIDTH/8-1:0] keep_q;
    logic                    abort_pend;

    logic handshake;
    logic launch;
    logic start_last;
    logic last_beat;
    logic last_pkt;
    logic next_last;
    logic gap_last;

    // The done cycle (FINISH) already accepts a new start.
    assign launch     = start && (state == IDLE || state == FINISH);
    assign handshake  = M_AXI_TVALID && M_AXI_TREADY;
    assign start_last = (cfg_pkt_len == LEN_ONE);

    stream_beat_ctr #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr       (launch),
        .beat_hs   (handshake),
        .gap_en    (state == GAP),
        .pkt_len   (len_q),
        .pkt_cnt   (cnt_q),
        .gap       (gap_q),
        .last_beat (last_beat),
        .last_pkt  (last_pkt),
        .next_last (next_last),
        .gap_last  (gap_last)
    );

    // Run FSM plus all registered stream and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            M_AXI_TVALID <= 1'b0;
            M_AXI_TLAST  <= 1'b0;
            M_AXI_TDATA  <= '0;
            M_AXI_TKEEP  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            beats_sent   <= '0;
            abort_pend   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    state <= IDLE;
                    if (start) begin
                        len_q       <= cfg_pkt_len;
                        cnt_q       <= cfg_pkt_cnt;
                        gap_q       <= cfg_gap;
                        mode_q      <= cfg_mode;
                        keep_q      <= cfg_last_keep;
                        beats_sent  <= '0;
                        aborted     <= 1'b0;
                        abort_pend  <= 1'b0;
                        M_AXI_TDATA <= cfg_seed;
                        M_AXI_TLAST <= start_last;
                        M_AXI_TKEEP <= start_last ? cfg_last_keep : '1;
                        if (cfg_pkt_len == '0 || cfg_pkt_cnt == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state        <= SEND;
                            M_AXI_TVALID <= 1'b1;
                            busy         <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (handshake) begin
                        beats_sent  <= beats_sent + 32'd1;
                        M_AXI_TLAST <= next_last;
                        M_AXI_TKEEP <= next_last ? keep_q : '1;
                        if (mode_q == MODE_INC) begin
                            M_AXI_TDATA <= M_AXI_TDATA + DATA_WIDTH'(1);
                        end
                        if (abort || abort_pend || (last_beat && last_pkt)) begin
                            state        <= FINISH;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            M_AXI_TVALID <= 1'b0;
                            abort_pend   <= 1'b0;
                            aborted      <= abort || abort_pend;
                        end else if (last_beat && gap_q != '0) begin
                            state        <= GAP;
                            M_AXI_TVALID <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state   <= FINISH;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (gap_last) begin
                        state        <= SEND;
                        M_AXI_TVALID <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Bench for stream_pattern_gen: directed scenarios with literal expectations
// plus randomized runs, all checked every cycle against a queue-based model.
module tb_stream_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] cfg_pkt_len;
    logic [15:0] cfg_pkt_cnt;
    logic [15:0] cfg_gap;
    logic        cfg_mode;
    logic [31:0] cfg_seed;
    logic [3:0]  cfg_last_keep;
    logic [31:0] M_AXI_TDATA;
    logic [3:0]  M_AXI_TKEEP;
    logic        M_AXI_TVALID;
    logic        M_AXI_TREADY;
    logic        M_AXI_TLAST;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] beats_sent;

    stream_pattern_gen #(
        .DATA_WIDTH (32),
        .LEN_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_pkt_cnt   (cfg_pkt_cnt),
        .cfg_gap       (cfg_gap),
        .cfg_mode      (cfg_mode),
        .cfg_seed      (cfg_seed),
        .cfg_last_keep (cfg_last_keep),
        .M_AXI_TDATA   (M_AXI_TDATA),
        .M_AXI_TKEEP   (M_AXI_TKEEP),
        .M_AXI_TVALID  (M_AXI_TVALID),
        .M_AXI_TREADY  (M_AXI_TREADY),
        .M_AXI_TLAST   (M_AXI_TLAST),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .beats_sent    (beats_sent)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t       m_q[$];
    beat_t       mb;
    int          cyc = 0;
    bit          m_active = 0;
    int          m_gap_left = 0;
    int          m_gap = 0;
    bit          m_abort_req = 0;
    bit          m_done = 0;
    bit          m_aborted = 0;
    logic [31:0] m_beats = 0;

    // The run is a queue of beats to emit; idle gap cycles are a countdown.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_q.delete();
            m_active = 0; m_gap_left = 0; m_abort_req = 0;
            m_done = 0; m_aborted = 0; m_beats = 0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (start) begin
                    int len;
                    int total;
                    len   = int'(cfg_pkt_len);
                    total = len * int'(cfg_pkt_cnt);
                    m_q.delete();
                    m_beats = 0; m_aborted = 0; m_abort_req = 0; m_gap_left = 0;
                    m_gap = int'(cfg_gap);
                    for (int i = 0; i < total; i++) begin
                        mb.data = cfg_mode ? cfg_seed : cfg_seed + i;
                        mb.last = ((i % len) == len - 1);
                        mb.keep = mb.last ? cfg_last_keep : 4'hF;
                        m_q.push_back(mb);
                    end
                    if (m_q.size() == 0) m_done = 1;
                    else m_active = 1;
                end
            end else if (m_gap_left == 0) begin
                if (abort) m_abort_req = 1;
                if (M_AXI_TREADY) begin
                    mb = m_q.pop_front();
                    m_beats = m_beats + 1;
                    if (m_abort_req || m_q.size() == 0) begin
                        m_active = 0; m_done = 1; m_aborted = m_abort_req;
                    end else if (mb.last) begin
                        m_gap_left = m_gap;
                    end
                end
            end else if (abort) begin
                m_active = 0; m_done = 1; m_aborted = 1;
            end else begin
                m_gap_left--;
            end
        end
    end

    // ---------------- checking ----------------
    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 0;
    logic [31:0] hs_data[$];
    logic [3:0]  hs_keep[$];
    logic        hs_last[$];
    int          hs_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    int          d0 = 0;
    bit          busy_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        bit m_valid;
        m_valid = m_active && (m_gap_left == 0);
        if (chk_en) begin
            chk("tvalid", 64'(M_AXI_TVALID), 64'(m_valid));
            if (m_valid) begin
                chk("tdata", 64'(M_AXI_TDATA), 64'(m_q[0].data));
                chk("tkeep", 64'(M_AXI_TKEEP), 64'(m_q[0].keep));
                chk("tlast", 64'(M_AXI_TLAST), 64'(m_q[0].last));
            end
            chk("busy", 64'(busy), 64'(m_active));
            chk("done", 64'(done), 64'(m_done));
            chk("aborted", 64'(aborted), 64'(m_aborted));
            chk("beats_sent", 64'(beats_sent), 64'(m_beats));
        end
        if (M_AXI_TVALID && M_AXI_TREADY) begin
            hs_data.push_back(M_AXI_TDATA);
            hs_keep.push_back(M_AXI_TKEEP);
            hs_last.push_back(M_AXI_TLAST);
            hs_cyc.push_back(cyc);
        end
        if (busy) busy_seen = 1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int len, input int cnt, input int gap, input bit mode,
                           input logic [31:0] seed, input logic [3:0] keep);
        cfg_pkt_len   = 16'(len);
        cfg_pkt_cnt   = 16'(cnt);
        cfg_gap       = 16'(gap);
        cfg_mode      = mode;
        cfg_seed      = seed;
        cfg_last_keep = keep;
    endtask

    task automatic launch();
        hs_data.delete(); hs_keep.delete(); hs_last.delete(); hs_cyc.delete();
        busy_seen = 0;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        for (int t = 0; t < budget && done_cnt == d0; t++) begin
            if (toggle) M_AXI_TREADY = ~M_AXI_TREADY;
            tick();
        end
        chk("done_seen", 64'(done_cnt != d0), 64'(1));
    endtask

    task automatic rand_cfg();
        set_cfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; M_AXI_TREADY = 1'b0;
        set_cfg(0, 0, 0, 1'b0, 32'h0, 4'h0);
        tick(); tick();
        chk("rst_tvalid", 64'(M_AXI_TVALID), 64'(0));
        chk("rst_tlast", 64'(M_AXI_TLAST), 64'(0));
        chk("rst_tdata", 64'(M_AXI_TDATA), 64'(0));
        chk("rst_tkeep", 64'(M_AXI_TKEEP), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_aborted", 64'(aborted), 64'(0));
        chk("rst_beats", 64'(beats_sent), 64'(0));
        rst = 1'b0;
        chk_en = 1;
        tick();

        // Back-to-back packets, incrementing data, sink always ready.
        set_cfg(4, 2, 0, 1'b0, 32'h10, 4'h3);
        M_AXI_TREADY = 1'b1;
        launch();
        wait_done(50, 1'b0);
        chk("t1_nbeats", 64'(hs_data.size()), 64'(8));
        if (hs_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t1_data", 64'(hs_data[i]), 64'(32'h10 + i));
                chk("t1_last", 64'(hs_last[i]), 64'(i == 3 || i == 7));
            end
            chk("t1_contig", 64'(hs_cyc[7] - hs_cyc[0]), 64'(7));
        end
        chk("t1_done_lat", 64'(done_cyc - start_cyc), 64'(8));
        chk("t1_beats", 64'(beats_sent), 64'(8));
        tick();

        // Same run with TREADY toggling.
        M_AXI_TREADY = 1'b1;
        launch();
        wait_done(50, 1'b1);
        chk("t2_nbeats", 64'(hs_data.size()), 64'(8));
        if (hs_data.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t2_data", 64'(hs_data[i]), 64'(32'h10 + i));
        end
        chk("t2_beats", 64'(beats_sent), 64'(8));
        tick();

        // Constant data with a two-cycle gap and partial last keep.
        set_cfg(3, 2, 2, 1'b1, 32'hA5A5A5A5, 4'h3);
        M_AXI_TREADY = 1'b1;
        launch();
        wait_done(50, 1'b0);
        chk("t3_nbeats", 64'(hs_data.size()), 64'(6));
        if (hs_data.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("t3_data", 64'(hs_data[i]), 64'(32'hA5A5A5A5));
                chk("t3_keep", 64'(hs_keep[i]), 64'((i % 3 == 2) ? 4'h3 : 4'hF));
            end
            chk("t3_idle_cycles", 64'(hs_cyc[3] - hs_cyc[2] - 1), 64'(2));
        end
        tick();

        // Zero-length run.
        set_cfg(0, 5, 0, 1'b0, 32'h1, 4'hF);
        launch();
        wait_done(10, 1'b0);
        chk("t4_done_lat", 64'(done_cyc - start_cyc), 64'(0));
        chk("t4_busy_seen", 64'(busy_seen), 64'(0));
        chk("t4_nbeats", 64'(hs_data.size()), 64'(0));
        tick();

        // Abort while the first beat is stalled.
        set_cfg(8, 1, 0, 1'b0, 32'h0, 4'hF);
        M_AXI_TREADY = 1'b0;
        launch();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(); tick();
        M_AXI_TREADY = 1'b1;
        wait_done(20, 1'b0);
        chk("t5_nbeats", 64'(hs_data.size()), 64'(1));
        if (hs_data.size() == 1) chk("t5_data", 64'(hs_data[0]), 64'(0));
        chk("t5_aborted", 64'(aborted), 64'(1));
        chk("t5_beats", 64'(beats_sent), 64'(1));
        tick();

        // Reset in the middle of a packet, then a fresh run.
        set_cfg(6, 2, 0, 1'b0, 32'h40, 4'hF);
        M_AXI_TREADY = 1'b1;
        launch();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_tvalid", 64'(M_AXI_TVALID), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        tick();
        set_cfg(2, 1, 0, 1'b0, 32'h100, 4'hF);
        launch();
        wait_done(20, 1'b0);
        chk("t6_nbeats", 64'(hs_data.size()), 64'(2));
        if (hs_data.size() == 2) begin
            chk("t6_data0", 64'(hs_data[0]), 64'(32'h100));
            chk("t6_data1", 64'(hs_data[1]), 64'(32'h101));
        end
        tick();

        // Randomized runs: random config, backpressure, aborts, stray starts.
        for (int r = 0; r < 30; r++) begin
            rand_cfg();
            if (r == 0) begin
                set_cfg(3, 2, 1, 1'b0, 32'hFFFF_FFFE, 4'h1);
            end
            M_AXI_TREADY = 1'($urandom_range(0, 1));
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int t = 0; t < 400 && (m_active || m_done); t++) begin
                M_AXI_TREADY = ($urandom_range(0, 3) != 0);
                abort = ($urandom_range(0, 39) == 0);
                start = ($urandom_range(0, 29) == 0);
                if (start) rand_cfg();
                tick();
            end
            start = 1'b0;
            abort = 1'b0;
            tick(); tick();
            chk("rand_run_idle", 64'(busy), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
